// File: rtl/apple_kbd_latch_pkg.sv
// apple_io_pkg: shared constants and types for the Apple II+ keyboard latch.
//   KBD_ADDR / KBDSTRB_ADDR : base addresses of the $C000 and $C010 soft switches
//   IO_PAGE_MASK            : selects the 16-byte window decoded by each switch
//   kbd_state_t             : keycode filter FSM states
//   KEY_NONE                : "no key" value for both keycode and ascii
//   in_window()             : true when an address falls in a switch's 16-byte window
package apple_io_pkg;

    localparam logic [15:0] KBD_ADDR     = 16'hC000;
    localparam logic [15:0] KBDSTRB_ADDR = 16'hC010;
    localparam logic [15:0] IO_PAGE_MASK = 16'hFFF0;

    localparam logic [7:0]  KEY_NONE     = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } kbd_state_t;

    function automatic logic in_window(input logic [15:0] a, input logic [15:0] base);
        return ((a & IO_PAGE_MASK) == base);
    endfunction

endpackage

// File: rtl/apple_kbd_latch_if.sv
// apple_kbd_latch_if: keyboard input and 6502 I/O bus signals of the latch.
//   keycode  : raw USB HID keycode (8'h00 = no key)
//   ascii    : translator output for keycode (8'h00 = unmapped)
//   bus_en   : one-cycle qualifier for a CPU access to the $C0xx page
//   addr     : CPU address
//   data_out : read data for $C000-$C01F
//   strobe   : keyboard strobe flag (bit 7 of KBD)
//   key_down : high while an accepted key is held
// Modports: master drives keycode/ascii/bus/address (translator + CPU side),
//           slave is the latch itself.
// Handshake: there is no valid/ready pair. bus_en qualifies exactly one cycle
// of addr as a CPU access; data_out is a pure function of addr and latch state
// and is valid in every cycle regardless of bus_en.
interface apple_kbd_latch_if;

    logic [7:0]  keycode;
    logic [7:0]  ascii;
    logic        bus_en;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        strobe;
    logic        key_down;

    modport master (
        output keycode,
        output ascii,
        output bus_en,
        output addr,
        input  data_out,
        input  strobe,
        input  key_down
    );

    modport slave (
        input  keycode,
        input  ascii,
        input  bus_en,
        input  addr,
        output data_out,
        output strobe,
        output key_down
    );

endinterface

// File: rtl/apple_kbd_latch_settle_cnt.sv
// kbd_settle_cnt: saturating up-counter with synchronous clear.
// Used for the keycode settle timer and the auto-repeat timer.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_clr   : synchronous clear (wins over i_en)
//   i_en    : count enable; the count holds at all-ones instead of wrapping
//   o_count : current count
module kbd_settle_cnt #(
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/apple_kbd_latch.sv
// apple_kbd_latch: Apple II+ keyboard data/strobe register.
// Accepts each new HID keycode once after it has been stable for SETTLE_CYCLES,
// latches the translated 7-bit ASCII, raises the strobe, and serves the
// $C000 (KBD) / $C010 (KBDSTRB) soft switches.
// Ports:
//   Clk         : system clock
//   Reset_n     : asynchronous assert, synchronous release, active low
//   kbd         : apple_kbd_latch_if.slave (keycode, ascii, bus_en, addr,
//                 data_out, strobe, key_down)
//   o_dbg_state : current filter FSM state
// Optional build macro: KBD_REPEAT_EN adds auto-repeat of the held key
// (first repeat after REPEAT_DELAY cycles, then every REPEAT_RATE cycles).
module apple_kbd_latch
    import apple_io_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 24000000,
    parameter int REPEAT_RATE   = 2400000
) (
    input  logic               Clk,
    input  logic               Reset_n,
    apple_kbd_latch_if.slave   kbd,
    output kbd_state_t         o_dbg_state
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("apple_kbd_latch: parameter out of range");
    end

    localparam int              CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    kbd_state_t       r_state;
    kbd_state_t       w_next_state;
    logic [7:0]       r_cand;
    logic [6:0]       r_kbd_char;
    logic             r_strobe;
    logic             r_key_down;

    logic [CNT_W-1:0] w_settle_cnt;
    logic             w_key_present;
    logic             w_key_same;
    logic             w_settle_done;
    logic             w_ascii_valid;
    logic             w_hold_key;
    logic             w_load_cand;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_accept;
    logic             w_rep_set;
    logic             w_strobe_set;
    logic             w_strobe_clr;

    assign w_key_present = (kbd.keycode != KEY_NONE);
    assign w_key_same    = (kbd.keycode == r_cand);
    assign w_settle_done = (w_settle_cnt == SETTLE_LAST);
    assign w_ascii_valid = (kbd.ascii != KEY_NONE);
    // Same key still down while resting in HELD.
    assign w_hold_key    = (r_state == HELD) && w_key_present && w_key_same;

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_key_present) w_next_state = SETTLE;
            end
            SETTLE: begin
                if (!w_key_present)    w_next_state = IDLE;
                else if (!w_key_same)  w_next_state = SETTLE;
                else if (w_settle_done) w_next_state = HELD;
            end
            HELD: begin
                if (!w_key_present)    w_next_state = IDLE;
                else if (!w_key_same)  w_next_state = SETTLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM action decode. The settle counter is held at zero everywhere except
    // while the candidate key stays stable in SETTLE, so every entry into
    // SETTLE starts from a fresh count.
    always_comb begin
        w_load_cand = 1'b0;
        w_cnt_clr   = 1'b1;
        w_cnt_en    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_load_cand = w_key_present;
            end
            SETTLE: begin
                if (w_key_present && !w_key_same) begin
                    w_load_cand = 1'b1;
                end else if (w_key_present) begin
                    w_cnt_clr = 1'b0;
                    w_cnt_en  = 1'b1;
                    w_accept  = w_settle_done;
                end
            end
            HELD: begin
                // Rollover straight into the next key.
                w_load_cand = w_key_present && !w_key_same;
            end
            default: begin
                w_load_cand = 1'b0;
            end
        endcase
    end

    kbd_settle_cnt #(.WIDTH(CNT_W)) u_settle_cnt (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_settle_cnt)
    );

`ifdef KBD_REPEAT_EN
    localparam int               REP_MAX        = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int               REP_W          = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] w_rep_cnt;
    logic             w_rep_run;
    logic             w_rep_hit;
    logic             r_rep_phase;   // 0: waiting for first repeat, 1: steady repeat

    // Runs only while a mapped key stays held; any exit from HELD zeroes it.
    assign w_rep_run = w_hold_key && r_key_down;
    assign w_rep_hit = w_rep_run &&
                       (w_rep_cnt == (r_rep_phase ? REP_RATE_LAST : REP_DELAY_LAST));

    kbd_settle_cnt #(.WIDTH(REP_W)) u_repeat_cnt (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_clr   (!w_rep_run || w_rep_hit),
        .i_en    (w_rep_run),
        .o_count (w_rep_cnt)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rep_phase <= 1'b0;
        end else if (!w_rep_run) begin
            r_rep_phase <= 1'b0;
        end else if (w_rep_hit) begin
            r_rep_phase <= 1'b1;
        end
    end

    assign w_rep_set = w_rep_hit;
`else
    assign w_rep_set = 1'b0;
`endif

    assign w_strobe_set = (w_accept && w_ascii_valid) || w_rep_set;
    // Any access (read or write) to $C010-$C01F clears the strobe.
    assign w_strobe_clr = kbd.bus_en && in_window(kbd.addr, KBDSTRB_ADDR);

    // Latch datapath.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cand     <= KEY_NONE;
            r_kbd_char <= 7'h00;
            r_strobe   <= 1'b0;
            r_key_down <= 1'b0;
        end else begin
            if (w_load_cand) begin
                r_cand <= kbd.keycode;
            end
            if (w_accept && w_ascii_valid) begin
                r_kbd_char <= kbd.ascii[6:0];
            end
            // Modifier/unmapped keys reach HELD with key_down low.
            if (w_accept) begin
                r_key_down <= w_ascii_valid;
            end else if (!w_hold_key) begin
                r_key_down <= 1'b0;
            end
            // A new key arriving with a clear must not be lost: set wins.
            if (w_strobe_set) begin
                r_strobe <= 1'b1;
            end else if (w_strobe_clr) begin
                r_strobe <= 1'b0;
            end
        end
    end

    // Read mux, independent of bus_en.
    always_comb begin
        kbd.data_out = 8'h00;
        if (in_window(kbd.addr, KBD_ADDR)) begin
            kbd.data_out = {r_strobe, r_kbd_char};
        end else if (in_window(kbd.addr, KBDSTRB_ADDR)) begin
            kbd.data_out = {r_key_down, r_kbd_char};
        end
    end

    assign kbd.strobe   = r_strobe;
    assign kbd.key_down = r_key_down;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/apple_kbd_latch.md
Name: apple_kbd_latch

Overview:
- Apple II+ keyboard data/strobe register, downstream of the USB-keycode-to-ASCII translator.
- Filters raw HID keycodes so each new keypress is accepted once, after the keycode has been stable for a settle time.
- Latches the translated 7-bit ASCII and raises the keyboard strobe.
- Exposes the $C000 (KBD) and $C010 (KBDSTRB) soft-switch behaviour to the 6502 bus decoder.

Parameters:
- SETTLE_CYCLES, 16: consecutive Clk cycles a nonzero keycode must hold before acceptance; legal range 1..65535.
- REPEAT_DELAY, 24000000: cycles a key must be held before the first auto-repeat (used only with KBD_REPEAT_EN).
- REPEAT_RATE, 2400000: cycles between subsequent auto-repeats (used only with KBD_REPEAT_EN).

Ports:
- Clk  input  1  system clock; the only clock.
- Reset_n  input  1  asynchronous, active-low reset.
- keycode  input  8  raw USB HID keycode, synchronous to Clk; 8'h00 means no key.
- ascii  input  8  translator output for the current keycode; 8'h00 means unmapped.
- bus_en  input  1  one-cycle qualifier for a CPU access to the $C0xx I/O page.
- addr  input  16  CPU address.
- data_out  output  8  read data for $C000-$C01F.
- strobe  output  1  keyboard strobe flag (bit 7 of KBD).
- key_down  output  1  high while an accepted key is held.

Behaviour:
- Reset (async assert, sync release): state=IDLE, strobe=0, kbd_char=7'h00, key_down=0, cand=8'h00, all counters 0. data_out therefore reads 8'h00.
- FSM states:
  - IDLE:
    - keycode!=0 -> SETTLE; cand<=keycode, cnt<=0.
  - SETTLE:
    - keycode==0 -> IDLE.
    - keycode!=cand and keycode!=0 -> restart SETTLE with the new cand, cnt<=0.
    - Otherwise cnt++.
    - When cnt==SETTLE_CYCLES-1 with keycode==cand:
      - If ascii!=0: kbd_char<=ascii[6:0], strobe<=1, key_down<=1, go HELD.
      - If ascii==0 (modifier or unmapped key): go HELD with strobe and kbd_char unchanged and key_down=0.
  - HELD:
    - keycode==0 -> IDLE, key_down<=0.
    - keycode!=cand and keycode!=0 -> SETTLE (rollover to a new key); key_down<=0.
    - keycode==cand -> stay.
- Acceptance latency: a key that is stable from cycle 0 has strobe=1 visible at cycle SETTLE_CYCLES+1.
- Strobe clear: bus_en=1 with addr in 16'hC010-16'hC01F, read or write, sets strobe<=0 next cycle.
- Simultaneous set and clear in the same cycle: set wins and strobe stays 1. The new key must not be lost.
- Read mux (combinational from registers):
  - addr 16'hC000-16'hC00F -> {strobe, kbd_char}.
  - addr 16'hC010-16'hC01F -> {key_down, kbd_char}.
  - Any other address -> 8'h00.
  - data_out does not depend on bus_en.
- Accesses outside $C000-$C01F have no effect on state.
- kbd_char holds its value after strobe clears and after key release; it is replaced only by the next accepted key.
- Bit 7 of ascii is ignored.
- Settle counter width is $clog2(SETTLE_CYCLES+1). The counter saturates and never wraps.
- Reset asserted mid-SETTLE or mid-HELD: immediate return to reset values. A key still held at reset release re-enters through IDLE->SETTLE and is accepted again.

Optional Feature:
- Macro: KBD_REPEAT_EN.
- Defined:
  - In HELD with key_down=1, a repeat counter runs.
  - After REPEAT_DELAY cycles, strobe<=1 (same kbd_char). After that, strobe<=1 again every REPEAT_RATE cycles.
  - The counter resets on any exit from HELD and on reset.
  - A repeat set coinciding with a $C010 clear: set wins.
- Undefined: no repeat counter is synthesised; one strobe per accepted press.

Decomposition:
- Package apple_io_pkg holds:
  - KBD_ADDR (16'hC000), KBDSTRB_ADDR (16'hC010), IO_PAGE_MASK (16'hFFF0).
  - typedef enum logic [1:0] kbd_state_t {IDLE, SETTLE, HELD}.
  - KEY_NONE (8'h00).
- One natural sub-module: kbd_settle_cnt, a parameterised saturating up-counter with sync clear, reused for the settle and repeat timers.

Test Plan:
- Press/accept:
  - Stimulus: reset, then keycode=8'h04, ascii=8'h41 held for 20 cycles.
  - Required: strobe rises exactly at cycle 17; a read of addr 16'hC000 returns 8'hC1; key_down=1.
- Bounce rejection:
  - Stimulus: keycode toggles 8'h04/8'h00 every 5 cycles for 100 cycles.
  - Required: strobe stays 0 and data_out at C000 stays 8'h00.
- Strobe clear:
  - Stimulus: after the press/accept scenario, bus_en=1 with addr=16'hC010 for one cycle.
  - Required: next cycle C000 reads 8'h41; C010 reads 8'hC1 while the key is held and 8'h41 after release.
- Rollover and modifier:
  - Stimulus: hold keycode 8'h05 (ascii 8'h42) until accepted, clear the strobe, then switch directly to 8'h06 (ascii 8'h43) for 20 cycles.
  - Required: second strobe with C000 reading 8'hC3.
  - Stimulus: keycode 8'hE1 with ascii 8'h00 held.
  - Required: no strobe and kbd_char unchanged.
- Set/clear collision and reset:
  - Stimulus: issue the $C010 clear in the exact cycle of acceptance.
  - Required: strobe=1 afterwards.
  - Stimulus: assert Reset_n=0 mid-SETTLE.
  - Required: all outputs 0 within the same cycle.
- KBD_REPEAT_EN (REPEAT_DELAY=50, REPEAT_RATE=10):
  - Stimulus: hold key 8'h04 and clear the strobe after each rise.
  - Required: strobe re-asserts at 50 cycles after acceptance, then every 10 cycles; stops on release.
